// File: rtl/sram_mem_controller.sv
// ============================================================================
// Module   : sram_mem_controller
// Purpose  : Splits 32-bit MEM-stage loads/stores into two timed 16-bit
//            asynchronous SRAM accesses (low half first), stalling via ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_controller #(
   parameter int unsigned ADDR_OFFSET = 1024,
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n
);

   localparam logic [1:0]  C_IDLE   = 2'd0;
   localparam logic [1:0]  C_LO     = 2'd1;
   localparam logic [1:0]  C_HI     = 2'd2;
   localparam logic [1:0]  C_DONE   = 2'd3;
   localparam logic [31:0] C_OFFSET = 32'(ADDR_OFFSET);
   localparam logic [3:0]  C_LAST   = 4'(WAIT_CYCLES - 1);

   if ((WAIT_CYCLES < 2) || (WAIT_CYCLES > 15)) begin : g_bad_wait_cycles
      $error("sram_mem_controller: WAIT_CYCLES must be in 2..15");
   end

   logic [1:0]         state_q,       state_d;
   logic [3:0]         cnt_q,         cnt_d;
   logic               is_wr_q,       is_wr_d;
   logic [31:0]        read_data_q,   read_data_d;
   logic [SRAM_AW-1:0] sram_addr_q,   sram_addr_d;
   logic [15:0]        sram_dq_out_q, sram_dq_out_d;
   logic               sram_dq_oe_q,  sram_dq_oe_d;
   logic               sram_we_n_q,   sram_we_n_d;

   logic [31:0]        offset_w;
   logic [31:0]        twice_word_w;
   logic [SRAM_AW-1:0] lo_addr_w;
   logic [SRAM_AW-1:0] hi_addr_w;
   logic [3:0]         cnt_inc_w;
   logic               last_w;
   logic               unused_addr_bits;

   // Half-word address 2w, where w is the 32-bit word index above the offset.
   assign offset_w     = address - C_OFFSET;
   assign twice_word_w = {1'b0, offset_w[31:2], 1'b0};
   assign lo_addr_w    = twice_word_w[SRAM_AW-1:0];
   assign hi_addr_w    = {sram_addr_q[SRAM_AW-1:1], 1'b1};
   assign unused_addr_bits = ^{offset_w[1:0], twice_word_w};

   assign cnt_inc_w = cnt_q + 4'd1;
   assign last_w    = (cnt_q == C_LAST);

   assign ready = ((state_q == C_IDLE) && !rd_en && !wr_en) || (state_q == C_DONE);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_wr_d       = is_wr_q;
      read_data_d   = read_data_q;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = sram_dq_oe_q;
      sram_we_n_d   = sram_we_n_q;

      case (state_q)
         C_IDLE: begin
            if (wr_en || rd_en) begin
               state_d     = C_LO;
               cnt_d       = 4'd0;
               is_wr_d     = wr_en;
               sram_addr_d = lo_addr_w;
               if (wr_en) begin
                  sram_dq_out_d = write_data[15:0];
                  sram_dq_oe_d  = 1'b1;
                  sram_we_n_d   = 1'b0;
               end else begin
                  sram_dq_oe_d  = 1'b0;
                  sram_we_n_d   = 1'b1;
               end
            end
         end

         C_LO: begin
            if (last_w) begin
               state_d     = C_HI;
               cnt_d       = 4'd0;
               sram_addr_d = hi_addr_w;
               if (is_wr_q) begin
                  sram_dq_out_d = write_data[31:16];
                  sram_we_n_d   = 1'b0;
               end else begin
                  read_data_d[15:0] = sram_dq_in;
                  sram_we_n_d       = 1'b1;
               end
            end else begin
               // Strobe is registered, so it is released one cycle early to
               // leave the final cycle of each half with we_n high.
               cnt_d       = cnt_inc_w;
               sram_we_n_d = !(is_wr_q && (cnt_inc_w != C_LAST));
            end
         end

         C_HI: begin
            if (last_w) begin
               state_d      = C_DONE;
               cnt_d        = 4'd0;
               sram_dq_oe_d = 1'b0;
               sram_we_n_d  = 1'b1;
               if (!is_wr_q) begin
                  read_data_d[31:16] = sram_dq_in;
               end
            end else begin
               cnt_d       = cnt_inc_w;
               sram_we_n_d = !(is_wr_q && (cnt_inc_w != C_LAST));
            end
         end

         default: begin
            state_d = C_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= C_IDLE;
         cnt_q         <= 4'd0;
         is_wr_q       <= 1'b0;
         read_data_q   <= 32'd0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= 16'd0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_wr_q       <= is_wr_d;
         read_data_q   <= read_data_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
      end
   end

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = sram_dq_out_q;
   assign sram_dq_oe  = sram_dq_oe_q;
   assign sram_we_n   = sram_we_n_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
// ============================================================================
// Module   : tb_sram_mem_controller
// Purpose  : Directed self-checking bench for sram_mem_controller with a
//            behavioural 16-bit SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_controller;

   localparam int WAIT = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   int checks = 0;
   int errors = 0;

   sram_mem_controller #(
      .ADDR_OFFSET(1024),
      .WAIT_CYCLES(WAIT),
      .SRAM_AW    (18)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_in (sram_dq_in),
      .sram_we_n  (sram_we_n)
   );

   always #5 clk = ~clk;

   // Small asynchronous SRAM: written while we_n is low, read combinationally.
   logic [15:0] mem [0:63];
   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
   end
   assign sram_dq_in = mem[sram_addr[5:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observes one access starting in the current cycle (cycle 0) until ready.
   task automatic run_access(output int done_cyc, output int lo_we, output int hi_we,
                             output logic [31:0] lo_addr, output logic [31:0] hi_addr,
                             output logic [31:0] lo_dq, output logic [31:0] hi_dq,
                             output logic lo_oe, output logic r0,
                             output logic [31:0] rdata_done);
      done_cyc = -1; lo_we = 0; hi_we = 0;
      lo_addr = '0; hi_addr = '0; lo_dq = '0; hi_dq = '0; lo_oe = 1'b0;
      rdata_done = '0;
      #1;
      r0 = ready;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k == 1) begin
            lo_addr = 32'(sram_addr); lo_dq = 32'(sram_dq_out); lo_oe = sram_dq_oe;
         end
         if (k == WAIT + 1) begin
            hi_addr = 32'(sram_addr); hi_dq = 32'(sram_dq_out);
         end
         if (!sram_we_n) begin
            if (k <= WAIT) lo_we++;
            else hi_we++;
         end
         if (ready) begin
            done_cyc = k;
            rdata_done = read_data;
            break;
         end
      end
   endtask

   initial begin
      int          done_cyc, lo_we, hi_we;
      logic [31:0] lo_addr, hi_addr, lo_dq, hi_dq, rdata_done;
      logic        lo_oe, r0;

      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      step(); step();
      rst = 1'b0;
      step();

      check("rst_ready",     32'(ready),       32'd1);
      check("rst_read_data", read_data,        32'd0);
      check("rst_sram_addr", 32'(sram_addr),   32'd0);
      check("rst_dq_out",    32'(sram_dq_out), 32'd0);
      check("rst_dq_oe",     32'(sram_dq_oe),  32'd0);
      check("rst_we_n",      32'(sram_we_n),   32'd1);
      step(); step(); step();
      check("idle_ready_holds", 32'(ready),    32'd1);

      // Store 0xDEADBEEF to byte 1028 -> SRAM words 2 and 3.
      wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("st_ready_c0",  32'(r0),       32'd0);
      check("st_done_cyc",  32'(done_cyc), 32'd11);
      check("st_lo_addr",   lo_addr,       32'd2);
      check("st_lo_dq",     lo_dq,         32'h0000BEEF);
      check("st_lo_oe",     32'(lo_oe),    32'd1);
      check("st_hi_addr",   hi_addr,       32'd3);
      check("st_hi_dq",     hi_dq,         32'h0000DEAD);
      check("st_lo_we_cnt", 32'(lo_we),    32'd4);
      check("st_hi_we_cnt", 32'(hi_we),    32'd4);
      check("st_done_oe",   32'(sram_dq_oe), 32'd0);
      check("st_done_we_n", 32'(sram_we_n),  32'd1);
      check("st_read_data_untouched", rdata_done, 32'd0);
      wr_en = 1'b0;
      step();
      check("st_idle_ready", 32'(ready), 32'd1);

      // Load back from 1028.
      rd_en = 1'b1; address = 32'd1028;
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("ld_ready_c0", 32'(r0),          32'd0);
      check("ld_done_cyc", 32'(done_cyc),    32'd11);
      check("ld_lo_addr",  lo_addr,          32'd2);
      check("ld_hi_addr",  hi_addr,          32'd3);
      check("ld_lo_oe",    32'(lo_oe),       32'd0);
      check("ld_we_cnt",   32'(lo_we + hi_we), 32'd0);
      check("ld_data",     rdata_done,       32'hDEADBEEF);
      rd_en = 1'b0;
      step(); step();
      check("ld_data_held", read_data, 32'hDEADBEEF);

      // Back-to-back store then load at 1024 (words 0/1).
      wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("b2b_st_done_cyc", 32'(done_cyc), 32'd11);
      check("b2b_st_lo_addr",  lo_addr,       32'd0);
      check("b2b_st_hi_addr",  hi_addr,       32'd1);
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("b2b_gap_single_ready", 32'(r0),       32'd0);
      check("b2b_ld_done_cyc",      32'(done_cyc), 32'd11);
      check("b2b_ld_data",          rdata_done,    32'h12345678);
      rd_en = 1'b0;
      step();

      // Both enables: write wins, read_data untouched.
      rd_en = 1'b1; wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("both_done_cyc", 32'(done_cyc), 32'd11);
      check("both_lo_addr",  lo_addr,       32'd4);
      check("both_hi_addr",  hi_addr,       32'd5);
      check("both_lo_we",    32'(lo_we),    32'd4);
      check("both_hi_we",    32'(hi_we),    32'd4);
      check("both_lo_dq",    lo_dq,         32'h0000F00D);
      check("both_read_data", rdata_done,   32'h12345678);
      rd_en = 1'b0; wr_en = 1'b0;
      step();

      // Reset while in the high half of a store to 1036 (words 6/7).
      wr_en = 1'b1; address = 32'd1036; write_data = 32'hA5A55A5A;
      for (int k = 1; k <= 7; k++) step();
      check("mid_hi_addr", 32'(sram_addr), 32'd7);
      check("mid_hi_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      step();
      check("mid_rst_we_n",      32'(sram_we_n),  32'd1);
      check("mid_rst_oe",        32'(sram_dq_oe), 32'd0);
      check("mid_rst_read_data", read_data,       32'd0);
      check("mid_rst_addr",      32'(sram_addr),  32'd0);
      rst = 1'b0; wr_en = 1'b0;
      #1;
      check("mid_rst_idle_ready", 32'(ready), 32'd1);
      step();

      rd_en = 1'b1; address = 32'd1028;
      run_access(done_cyc, lo_we, hi_we, lo_addr, hi_addr, lo_dq, hi_dq, lo_oe, r0, rdata_done);
      check("post_rst_done_cyc", 32'(done_cyc), 32'd11);
      check("post_rst_ld_data",  rdata_done,    32'hDEADBEEF);
      rd_en = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
- Replaces the single-cycle data memory.
- Splits each 32-bit load/store into two timed SRAM half-word accesses, low half first.
- Drives `ready` low while busy; the top level uses it to freeze the IF/ID/EXE/MEM pipeline registers.

Parameters:
- ADDR_OFFSET, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5: cycles each half-word access is held. Legal range 2..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from the EXE/MEM register.
- wr_en  in  1  store request from the EXE/MEM register.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value.
- read_data  out  32  load result; valid when `ready`=1 in DONE.
- ready  out  1  1 = no request pending or access complete; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data to the SRAM bus.
- sram_dq_oe  out  1  1 = controller drives the data bus.
- sram_dq_in  in  16  read data from the SRAM bus.
- sram_we_n  out  1  active-low SRAM write enable.

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high. All state changes occur on the rising edge of `clk`.
- Reset, including mid-operation: state goes to IDLE and the cycle counter to 0.
  - Reset values: read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - Any in-flight access is abandoned. No partial-completion signalling.
- Address mapping:
  - w = (address − ADDR_OFFSET) >> 2, modulo 32-bit arithmetic.
  - Low half goes to SRAM address 2w, high half to 2w+1. Both are truncated to SRAM_AW bits.
  - No range check: out-of-range addresses wrap.
- `ready` is combinational: ready = (state==IDLE && !rd_en && !wr_en) || state==DONE.
- FSM states: IDLE, LO, HI, DONE. A counter `cnt` runs from 0 to WAIT_CYCLES−1.
  - IDLE:
    - If wr_en or rd_en is set, latch op (write if wr_en, otherwise read), set sram_addr=2w, cnt=0, and go to LO.
    - For a write, also set sram_dq_out=write_data[15:0] and sram_dq_oe=1.
    - wr_en has priority when both enables are high.
  - LO: held for WAIT_CYCLES cycles.
    - Write: sram_we_n=0 for cnt 0..WAIT_CYCLES−2, and 1 on the final cycle.
    - Read: sram_we_n=1 throughout, sram_dq_oe=0. On the final cycle, capture read_data[15:0] ← sram_dq_in.
    - On the final cycle, go to HI with cnt=0, sram_addr=2w+1, and sram_dq_out=write_data[31:16] for a write.
  - HI: same timing as LO.
    - A read captures read_data[31:16] on the final cycle.
    - Go to DONE. sram_dq_oe←0, sram_we_n←1.
  - DONE: lasts one cycle with ready=1, then unconditionally returns to IDLE. A request present in IDLE on the next cycle starts a new access.
- Latency from a request seen in IDLE at cycle 0:
  - `ready`=0 for cycles 0..2·WAIT_CYCLES; ready=1 at cycle 2·WAIT_CYCLES+1.
  - With defaults: 11 stall cycles.
- Input holding: the requester holds address, write_data, rd_en and wr_en stable while ready=0. The controller uses only the values latched in IDLE. The data halves come from the live write_data, which is stable under freeze.
- sram_addr and sram_dq_out hold their last values in IDLE and DONE. sram_we_n is 1 outside write phases.
- read_data is changed only by reads and holds until the next read completes. Writes never alter it.

Test Plan:
- Reset, no requests: all outputs at reset values, ready=1, state stays IDLE.
- Store wr_en=1, address=1028, write_data=0xDEADBEEF, defaults:
  - ready=0 for 11 cycles.
  - sram_addr=2 with dq_out=0xBEEF, then sram_addr=3 with dq_out=0xDEAD.
  - sram_we_n low exactly 4 cycles per half.
  - ready=1 at cycle 11.
- Load rd_en=1, address=1028, SRAM model returning the stored halves: read_data=0xDEADBEEF at the DONE cycle, then held after rd_en drops.
- Back-to-back store then load to address=1024, value 0x12345678:
  - Second access starts the cycle after DONE.
  - Total ready=1 cycles between them = 1.
  - Load returns 0x12345678.
- rd_en=1 and wr_en=1 together at address=1032: treated as a write (sram_we_n pulses, sram_addr=4/5), and read_data is unchanged.
- rst asserted in HI of a store: next cycle IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0. A subsequent load completes normally in 11 cycles.
